// File: rtl/mem_wb_pipe_pkg.sv
// Shared widths and funct3 load/store encodings for the MEM stage.
package mem_wb_pipe_pkg;

   localparam int XLEN = 32;
   localparam int RA_W = 5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
      logic [2:0]      funct3;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] alu_res;
      logic [XLEN-1:0] rs2_data;
   } exmem_t;

   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic [RA_W-1:0] rd;
      logic [XLEN-1:0] wdata;
   } memwb_t;

endpackage

// File: rtl/mem_wb_pipe_load_align.sv
// Load data alignment: picks byte/half/word by address, sign/zero extends.
module mem_load_align
   import mem_wb_pipe_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] value
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        uns;

   always_comb begin
      uns      = funct3[2];
      byte_sel = rdata[7:0];
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
      unique case (addr_lo)
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      value = rdata;
      unique case (funct3[1:0])
         2'b00: value = {{24{~uns & byte_sel[7]}}, byte_sel};
         2'b01: value = {{16{~uns & half_sel[15]}}, half_sel};
         default: value = rdata;
      endcase
   end

endmodule

// File: rtl/mem_wb_pipe.sv
// EX/MEM + MEM/WB registers and MEM stage; `MEM_MISALIGN_CHK_EN adds the misalign output.
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   input  logic            ex_regwrite,
   input  logic            ex_memread,
   input  logic            ex_memwrite,
   input  logic [2:0]      ex_funct3,
   input  logic [RA_W-1:0] ex_rd,
   input  logic [XLEN-1:0] ex_alu_res,
   input  logic [XLEN-1:0] ex_rs2_data,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            mem_stall,
`ifdef MEM_MISALIGN_CHK_EN
   output logic            misalign,
`endif
   output logic            exmem_regwrite,
   output logic [RA_W-1:0] exmem_rd,
   output logic [XLEN-1:0] exmem_alu_res,
   output logic            memwb_regwrite,
   output logic [RA_W-1:0] memwb_rd,
   output logic [XLEN-1:0] memwb_wdata
);

   exmem_t exmem_q, exmem_d;
   memwb_t memwb_q, memwb_d;

   logic            req_raw;
   logic            mis;
   logic [1:0]      a_lo;
   logic [XLEN-1:0] load_val;

   assign a_lo = exmem_q.alu_res[1:0];

   mem_load_align u_align (
      .rdata   (dmem_rdata),
      .addr_lo (a_lo),
      .funct3  (exmem_q.funct3),
      .value   (load_val)
   );

   always_comb begin
      req_raw = exmem_q.valid & (exmem_q.memread | exmem_q.memwrite);
`ifdef MEM_MISALIGN_CHK_EN
      mis = req_raw &
            (((exmem_q.funct3[1:0] == 2'b01) & a_lo[0]) |
             ((exmem_q.funct3[1:0] == 2'b10) & (a_lo != 2'b00)));
      misalign = mis;
`else
      mis = 1'b0;
`endif
      dmem_req  = req_raw & ~mis;
      dmem_we   = dmem_req & exmem_q.memwrite;
      mem_stall = dmem_req & ~dmem_ready;
      dmem_addr = {exmem_q.alu_res[XLEN-1:2], 2'b00};

      dmem_wdata = exmem_q.rs2_data;
      dmem_be    = 4'b1111;
      unique case (exmem_q.funct3[1:0])
         2'b00: begin
            dmem_wdata = {4{exmem_q.rs2_data[7:0]}};
            dmem_be    = 4'b0001 << a_lo;
         end
         2'b01: begin
            dmem_wdata = {2{exmem_q.rs2_data[15:0]}};
            dmem_be    = a_lo[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            dmem_wdata = exmem_q.rs2_data;
            dmem_be    = 4'b1111;
         end
      endcase

      exmem_regwrite = exmem_q.valid & exmem_q.regwrite & (exmem_q.rd != '0);
      exmem_rd       = exmem_q.rd;
      exmem_alu_res  = exmem_q.alu_res;

      exmem_d = exmem_q;
      memwb_d = '0;
      if (!mem_stall) begin
         exmem_d.valid    = ex_valid;
         exmem_d.regwrite = ex_regwrite;
         exmem_d.memread  = ex_memread;
         exmem_d.memwrite = ex_memwrite;
         exmem_d.funct3   = ex_funct3;
         exmem_d.rd       = ex_rd;
         exmem_d.alu_res  = ex_alu_res;
         exmem_d.rs2_data = ex_rs2_data;
         memwb_d.valid    = exmem_q.valid;
         memwb_d.regwrite = exmem_regwrite & ~mis;
         memwb_d.rd       = exmem_q.rd;
         memwb_d.wdata    = exmem_q.memread ? load_val : exmem_q.alu_res;
      end

      memwb_regwrite = memwb_q.valid & memwb_q.regwrite & (memwb_q.rd != '0);
      memwb_rd       = memwb_q.rd;
      memwb_wdata    = memwb_q.wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe (default build).
module tb_mem_wb_pipe;
   import mem_wb_pipe_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            ex_valid, ex_regwrite, ex_memread, ex_memwrite;
   logic [2:0]      ex_funct3;
   logic [RA_W-1:0] ex_rd;
   logic [XLEN-1:0] ex_alu_res, ex_rs2_data;
   logic            dmem_req, dmem_we;
   logic [XLEN-1:0] dmem_addr, dmem_wdata;
   logic [3:0]      dmem_be;
   logic            dmem_ready;
   logic [XLEN-1:0] dmem_rdata;
   logic            mem_stall;
   logic            exmem_regwrite;
   logic [RA_W-1:0] exmem_rd;
   logic [XLEN-1:0] exmem_alu_res;
   logic            memwb_regwrite;
   logic [RA_W-1:0] memwb_rd;
   logic [XLEN-1:0] memwb_wdata;

   int n_cmp = 0;
   int n_err = 0;

   mem_wb_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
      .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_funct3(ex_funct3), .ex_rd(ex_rd),
      .ex_alu_res(ex_alu_res), .ex_rs2_data(ex_rs2_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
      .exmem_alu_res(exmem_alu_res),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
      .memwb_wdata(memwb_wdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ex(input logic v, input logic rw, input logic mr,
                           input logic mw, input logic [2:0] f3,
                           input logic [RA_W-1:0] rd,
                           input logic [XLEN-1:0] alu,
                           input logic [XLEN-1:0] rs2);
      ex_valid    = v;
      ex_regwrite = rw;
      ex_memread  = mr;
      ex_memwrite = mw;
      ex_funct3   = f3;
      ex_rd       = rd;
      ex_alu_res  = alu;
      ex_rs2_data = rs2;
   endtask

   task automatic idle();
      drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, '0, '0, '0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      dmem_ready = 1'b1;
      dmem_rdata = '0;
      #12;
      n_cmp++;
      if ({dmem_req, dmem_we, mem_stall, exmem_regwrite, memwb_regwrite} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctrl got=%b want=00000",
                  {dmem_req, dmem_we, mem_stall, exmem_regwrite, memwb_regwrite});
      end
      n_cmp++;
      if ({exmem_rd, exmem_alu_res, memwb_rd, memwb_wdata} !== '0) begin
         n_err++;
         $display("FAIL reset_data exrd=%0d exalu=%h wbrd=%0d wbdata=%h want all 0",
                  exmem_rd, exmem_alu_res, memwb_rd, memwb_wdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_alu();
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, F3_W, 5'd5, 32'h1234, 32'h0);
      tick();
      idle();
      n_cmp++;
      if (exmem_rd !== 5'd5 || exmem_regwrite !== 1'b1 || exmem_alu_res !== 32'h1234) begin
         n_err++;
         $display("FAIL alu_exmem rd=%0d rw=%b alu=%h want 5 1 00001234",
                  exmem_rd, exmem_regwrite, exmem_alu_res);
      end
      tick();
      n_cmp++;
      if (memwb_rd !== 5'd5 || memwb_regwrite !== 1'b1 || memwb_wdata !== 32'h1234) begin
         n_err++;
         $display("FAIL alu_memwb rd=%0d rw=%b wd=%h want 5 1 00001234",
                  memwb_rd, memwb_regwrite, memwb_wdata);
      end
   endtask

   task automatic test_x0();
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, F3_W, 5'd0, 32'h7777, 32'h0);
      tick();
      idle();
      n_cmp++;
      if (exmem_regwrite !== 1'b0) begin
         n_err++;
         $display("FAIL x0_exmem rw=%b want 0", exmem_regwrite);
      end
      tick();
      n_cmp++;
      if (memwb_regwrite !== 1'b0) begin
         n_err++;
         $display("FAIL x0_memwb rw=%b want 0", memwb_regwrite);
      end
   endtask

   task automatic test_loads();
      logic [2:0]      f3s [4];
      logic [XLEN-1:0] addrs [4];
      logic [XLEN-1:0] rds [4];
      logic [XLEN-1:0] exp [4];
      f3s[0] = F3_B;  addrs[0] = 32'h103; rds[0] = 32'h80FF_0000; exp[0] = 32'hFFFF_FF80;
      f3s[1] = F3_BU; addrs[1] = 32'h103; rds[1] = 32'h80FF_0000; exp[1] = 32'h0000_0080;
      f3s[2] = F3_H;  addrs[2] = 32'h102; rds[2] = 32'h8001_7F00; exp[2] = 32'hFFFF_8001;
      f3s[3] = F3_HU; addrs[3] = 32'h100; rds[3] = 32'h1234_9ABC; exp[3] = 32'h0000_9ABC;
      for (int i = 0; i < 4; i++) begin
         drive_ex(1'b1, 1'b1, 1'b1, 1'b0, f3s[i], 5'd10, addrs[i], 32'h0);
         tick();
         idle();
         dmem_rdata = rds[i];
         n_cmp++;
         if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL load_req[%0d] req=%b we=%b addr=%h want 1 0 00000100",
                     i, dmem_req, dmem_we, dmem_addr);
         end
         tick();
         n_cmp++;
         if (memwb_wdata !== exp[i] || memwb_regwrite !== 1'b1 || memwb_rd !== 5'd10) begin
            n_err++;
            $display("FAIL load_data[%0d] wd=%h rw=%b rd=%0d want %h 1 10",
                     i, memwb_wdata, memwb_regwrite, memwb_rd, exp[i]);
         end
      end
   endtask

   task automatic test_stores();
      logic [2:0]      f3s [3];
      logic [XLEN-1:0] addrs [3];
      logic [XLEN-1:0] rs2s [3];
      logic [XLEN-1:0] ewd [3];
      logic [3:0]      ebe [3];
      f3s[0] = F3_H; addrs[0] = 32'h102; rs2s[0] = 32'hABCD_1234;
      ewd[0] = 32'h1234_1234; ebe[0] = 4'b1100;
      f3s[1] = F3_B; addrs[1] = 32'h101; rs2s[1] = 32'h0000_00AB;
      ewd[1] = 32'hABAB_ABAB; ebe[1] = 4'b0010;
      f3s[2] = F3_W; addrs[2] = 32'h104; rs2s[2] = 32'hCAFE_F00D;
      ewd[2] = 32'hCAFE_F00D; ebe[2] = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         drive_ex(1'b1, 1'b0, 1'b0, 1'b1, f3s[i], 5'd0, addrs[i], rs2s[i]);
         tick();
         idle();
         n_cmp++;
         if (dmem_be !== ebe[i] || dmem_wdata !== ewd[i] || dmem_we !== 1'b1 ||
             dmem_req !== 1'b1) begin
            n_err++;
            $display("FAIL store[%0d] be=%b wd=%h we=%b req=%b want %b %h 1 1",
                     i, dmem_be, dmem_wdata, dmem_we, dmem_req, ebe[i], ewd[i]);
         end
         tick();
         n_cmp++;
         if (memwb_regwrite !== 1'b0) begin
            n_err++;
            $display("FAIL store_wb[%0d] rw=%b want 0", i, memwb_regwrite);
         end
      end
   endtask

   task automatic test_nomem_no_stall();
      dmem_ready = 1'b0;
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, F3_W, 5'd3, 32'h4242, 32'h0);
      tick();
      idle();
      n_cmp++;
      if (mem_stall !== 1'b0 || dmem_req !== 1'b0) begin
         n_err++;
         $display("FAIL nomem_stall stall=%b req=%b want 0 0", mem_stall, dmem_req);
      end
      tick();
      n_cmp++;
      if (memwb_wdata !== 32'h4242 || memwb_regwrite !== 1'b1) begin
         n_err++;
         $display("FAIL nomem_wb wd=%h rw=%b want 00004242 1", memwb_wdata, memwb_regwrite);
      end
      dmem_ready = 1'b1;
   endtask

   task automatic test_stall();
      int stalls = 0;
      dmem_ready = 1'b1;
      drive_ex(1'b1, 1'b1, 1'b1, 1'b0, F3_W, 5'd7, 32'h200, 32'h0);
      tick();
      dmem_ready = 1'b0;
      drive_ex(1'b1, 1'b1, 1'b0, 1'b0, F3_W, 5'd8, 32'h55, 32'h0);
      for (int c = 0; c < 3; c++) begin
         #1;
         if (mem_stall === 1'b1) stalls++;
         n_cmp++;
         if (exmem_rd !== 5'd7 || dmem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL stall_hold[%0d] exrd=%0d addr=%h want 7 00000200",
                     c, exmem_rd, dmem_addr);
         end
         tick();
         n_cmp++;
         if (memwb_regwrite !== 1'b0) begin
            n_err++;
            $display("FAIL stall_bubble[%0d] rw=%b want 0", c, memwb_regwrite);
         end
      end
      n_cmp++;
      if (stalls != 3) begin
         n_err++;
         $display("FAIL stall_count got=%0d want 3", stalls);
      end
      dmem_ready = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      tick();
      idle();
      n_cmp++;
      if (memwb_wdata !== 32'hDEAD_BEEF || memwb_rd !== 5'd7 || memwb_regwrite !== 1'b1 ||
          exmem_rd !== 5'd8) begin
         n_err++;
         $display("FAIL stall_wb wd=%h rd=%0d rw=%b exrd=%0d want deadbeef 7 1 8",
                  memwb_wdata, memwb_rd, memwb_regwrite, exmem_rd);
      end
      tick();
      n_cmp++;
      if (memwb_rd !== 5'd8 || memwb_wdata !== 32'h55 || memwb_regwrite !== 1'b1) begin
         n_err++;
         $display("FAIL stall_next rd=%0d wd=%h rw=%b want 8 00000055 1",
                  memwb_rd, memwb_wdata, memwb_regwrite);
      end
   endtask

   task automatic test_reset_mid_wait();
      dmem_ready = 1'b1;
      drive_ex(1'b1, 1'b1, 1'b1, 1'b0, F3_W, 5'd9, 32'h300, 32'h0);
      tick();
      idle();
      dmem_ready = 1'b0;
      #1;
      n_cmp++;
      if (mem_stall !== 1'b1) begin
         n_err++;
         $display("FAIL rstwait_pre stall=%b want 1", mem_stall);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({dmem_req, dmem_we, mem_stall, exmem_regwrite, memwb_regwrite} !== 5'b0 ||
          exmem_rd !== '0 || memwb_wdata !== '0) begin
         n_err++;
         $display("FAIL rstwait_clear req=%b stall=%b exrw=%b wbrw=%b exrd=%0d want all 0",
                  dmem_req, mem_stall, exmem_regwrite, memwb_regwrite, exmem_rd);
      end
      tick();
      rst_n = 1'b1;
      dmem_ready = 1'b1;
      dmem_rdata = 32'h1111_2222;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++;
         if (memwb_regwrite !== 1'b0 || exmem_regwrite !== 1'b0) begin
            n_err++;
            $display("FAIL rstwait_nowb[%0d] wbrw=%b exrw=%b want 0 0",
                     c, memwb_regwrite, exmem_regwrite);
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_x0();
      test_loads();
      test_stores();
      test_nomem_no_stall();
      test_stall();
      test_reset_mid_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
